// File: rtl/multicore_ctrl_if.sv
// Shared-memory control bundle between the cores and multicore_ctrl.
// master: core side drives requests/commands; slave: controller side.
interface multicore_ctrl_if #(
  parameter int NCORES = 4,
  parameter int IDW    = 2
);
  logic [NCORES-1:0]     halt_in;
  logic [NCORES-1:0]     wen;
  logic [NCORES-1:0]     rreq;
  logic [NCORES-1:0]     pr_valid;
  logic [NCORES-1:0]     pr_run;
  logic [NCORES*IDW-1:0] pr_target;
  logic [3*NCORES-1:0]   stall_num;
  logic [NCORES-1:0]     wgrant;
  logic [NCORES-1:0]     rgrant;
  logic [NCORES-1:0]     running;
  logic                  halt;
  logic [15:0]           conflicts;

  modport master (
    output halt_in, wen, rreq, pr_valid, pr_run, pr_target,
    input  stall_num, wgrant, rgrant, running, halt, conflicts
  );

  modport slave (
    input  halt_in, wen, rreq, pr_valid, pr_run, pr_target,
    output stall_num, wgrant, rgrant, running, halt, conflicts
  );
endinterface

// File: rtl/multicore_ctrl.sv
// Multicore shared-memory controller: pause/resume, round-robin write and
// data-read arbitration, per-core stall counts and sticky system halt.
// Ports: clk, reset (sync, active high), bus (multicore_ctrl_if.slave).
// Optional: MULTICORE_CTRL_CONFLICT_CNT_EN enables the 16-bit conflict
// counter; otherwise bus.conflicts is tied to zero.
module multicore_ctrl #(
  parameter int NCORES   = 4,
  parameter int IDW      = 2,
  parameter int STALL_PR = 6,
  parameter int STALL_WR = 6,
  parameter int STALL_RD = 3,
  parameter logic [NCORES-1:0] RUN_INIT = '1
) (
  input logic             clk,
  input logic             reset,
  multicore_ctrl_if.slave bus
);

  logic [NCORES-1:0] running_q;
  logic [NCORES-1:0] cmd_v;
  logic [NCORES-1:0] cmd_r;
  logic [NCORES-1:0] blocked;
  logic [NCORES-1:0] wg;
  logic [NCORES-1:0] rg;
  logic [IDW-1:0]    wptr_q;
  logic [IDW-1:0]    rptr_q;
  logic [IDW-1:0]    wptr_d;
  logic [IDW-1:0]    rptr_d;
  logic              halt_q;
  logic [3*NCORES-1:0] stall;

  // Scan from ptr outward; descending loop so the closest wins last.
  function automatic logic [NCORES-1:0] rr_pick(
    input logic [NCORES-1:0] req,
    input logic [IDW-1:0]    ptr
  );
    int idx;
    rr_pick = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NCORES) idx = idx - NCORES;
      if (req[idx]) begin
        rr_pick      = '0;
        rr_pick[idx] = 1'b1;
      end
    end
  endfunction

  function automatic logic [IDW-1:0] next_ptr(
    input logic [NCORES-1:0] g,
    input logic [IDW-1:0]    cur
  );
    next_ptr = cur;
    for (int i = 0; i < NCORES; i++)
      if (g[i])
        next_ptr = (i == NCORES - 1) ? '0 : IDW'(i + 1);
  endfunction

  // Per target, lowest issuer wins: walk issuers high to low.
  // Out-of-range targets never match any t and drop out.
  always_comb begin
    cmd_v = '0;
    cmd_r = '0;
    for (int t = 0; t < NCORES; t++) begin
      for (int i = NCORES - 1; i >= 0; i--) begin
        if (bus.pr_valid[i] &&
            bus.pr_target[i*IDW +: IDW] == IDW'(t)) begin
          cmd_v[t] = 1'b1;
          cmd_r[t] = bus.pr_run[i];
        end
      end
    end
  end

  assign blocked = (cmd_v & ~cmd_r)
                 | (~running_q & ~(cmd_v & cmd_r));

  always_comb begin
    wg     = rr_pick(bus.wen  & ~blocked, wptr_q);
    rg     = rr_pick(bus.rreq & ~blocked, rptr_q);
    wptr_d = next_ptr(wg, wptr_q);
    rptr_d = next_ptr(rg, rptr_q);
  end

  always_comb begin
    stall = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (blocked[i])
        stall[i*3 +: 3] = 3'(STALL_PR);
      else if (bus.wen[i] && !wg[i])
        stall[i*3 +: 3] = 3'(STALL_WR);
      else if (bus.rreq[i] && !rg[i])
        stall[i*3 +: 3] = 3'(STALL_RD);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      running_q <= RUN_INIT;
      wptr_q    <= '0;
      rptr_q    <= '0;
      halt_q    <= 1'b0;
    end else begin
      running_q <= (running_q & ~cmd_v) | (cmd_v & cmd_r);
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      if (&bus.halt_in) halt_q <= 1'b1;
    end
  end

`ifdef MULTICORE_CTRL_CONFLICT_CNT_EN
  logic        conflict;
  logic [15:0] conf_q;

  // Pause blocks are not arbitration losses.
  assign conflict = |(~blocked & ((bus.wen  & ~wg) |
                                  (bus.rreq & ~rg)));

  always_ff @(posedge clk) begin
    if (reset)
      conf_q <= '0;
    else if (conflict && conf_q != 16'hFFFF)
      conf_q <= conf_q + 16'd1;
  end

  assign bus.conflicts = conf_q;
`else
  assign bus.conflicts = '0;
`endif

  assign bus.wgrant    = wg;
  assign bus.rgrant    = rg;
  assign bus.stall_num = stall;
  assign bus.running   = running_q;
  assign bus.halt      = halt_q;

endmodule

// File: tb/tb_multicore_ctrl.sv
// Self-checking bench for multicore_ctrl: directed scenarios plus
// randomized traffic compared against a behavioural reference model.
module tb_multicore_ctrl;
  localparam int N = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicore_ctrl_if #(.NCORES(N), .IDW(W)) bus ();

  multicore_ctrl #(.NCORES(N), .IDW(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // reference model state and next state
  bit m_run[N];
  int m_wptr, m_rptr, m_conf;
  bit m_halt;
  bit n_run[N];
  int n_wptr, n_rptr, n_conf;
  bit n_halt;
  logic [N-1:0] e_wg, e_rg;
  int e_st[N];

  function automatic logic [N-1:0] run_vec();
    for (int i = 0; i < N; i++) run_vec[i] = m_run[i];
  endfunction

  task automatic model_eval();
    bit wv[N], wr[N], blk[N];
    int ew, er, tg;
    bit lose;
    for (int t = 0; t < N; t++) begin
      wv[t] = 0;
      wr[t] = 0;
    end
    for (int i = 0; i < N; i++) begin
      tg = int'(bus.pr_target[i*W +: W]);
      if (bus.pr_valid[i] && tg < N && !wv[tg]) begin
        wv[tg] = 1;
        wr[tg] = bus.pr_run[i];
      end
    end
    for (int i = 0; i < N; i++)
      blk[i] = (wv[i] && !wr[i]) || (!m_run[i] && !(wv[i] && wr[i]));
    ew = -1;
    er = -1;
    for (int k = 0; k < N; k++) begin
      if (ew < 0 && bus.wen[(m_wptr + k) % N] && !blk[(m_wptr + k) % N])
        ew = (m_wptr + k) % N;
      if (er < 0 && bus.rreq[(m_rptr + k) % N] && !blk[(m_rptr + k) % N])
        er = (m_rptr + k) % N;
    end
    e_wg = '0;
    e_rg = '0;
    if (ew >= 0) e_wg[ew] = 1'b1;
    if (er >= 0) e_rg[er] = 1'b1;
    lose = 0;
    for (int i = 0; i < N; i++) begin
      if (blk[i]) e_st[i] = 6;
      else if (bus.wen[i] && ew != i) begin e_st[i] = 6; lose = 1; end
      else if (bus.rreq[i] && er != i) begin e_st[i] = 3; lose = 1; end
      else e_st[i] = 0;
      n_run[i] = wv[i] ? wr[i] : m_run[i];
    end
    n_wptr = (ew >= 0) ? (ew + 1) % N : m_wptr;
    n_rptr = (er >= 0) ? (er + 1) % N : m_rptr;
    n_halt = m_halt || (bus.halt_in == '1);
    n_conf = m_conf;
`ifdef MULTICORE_CTRL_CONFLICT_CNT_EN
    if (lose && m_conf < 65535) n_conf = m_conf + 1;
`endif
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < N; i++) m_run[i] = 1;
      m_wptr = 0;
      m_rptr = 0;
      m_halt = 0;
      m_conf = 0;
    end else begin
      for (int i = 0; i < N; i++) m_run[i] = n_run[i];
      m_wptr = n_wptr;
      m_rptr = n_rptr;
      m_halt = n_halt;
      m_conf = n_conf;
    end
    @(negedge clk);
  endtask

  task automatic clear_in();
    bus.halt_in   = '0;
    bus.wen       = '0;
    bus.rreq      = '0;
    bus.pr_valid  = '0;
    bus.pr_run    = '0;
    bus.pr_target = '0;
  endtask

  task automatic set_cmd(input int who, input int tgt, input bit run);
    bus.pr_valid[who]        = 1'b1;
    bus.pr_run[who]          = run;
    bus.pr_target[who*W +: W] = W'(tgt);
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1'b1;
    set_cmd(0, 2, 1'b0);
    bus.wen     = 4'b1111;
    bus.halt_in = 4'b1111;
    tick();
    reset = 1'b0;
    clear_in();
    #1;
    checks++;
    if (bus.running !== 4'b1111) begin
      errors++;
      $display("FAIL reset_running: got %b expected 1111", bus.running);
    end
    checks++;
    if (bus.halt !== 1'b0) begin
      errors++;
      $display("FAIL reset_halt: got %b expected 0", bus.halt);
    end
    checks++;
    if (bus.conflicts !== 16'h0) begin
      errors++;
      $display("FAIL reset_conflicts: got %h expected 0000", bus.conflicts);
    end
    checks++;
    if (bus.wgrant !== 4'b0000 || bus.stall_num !== 12'h000) begin
      errors++;
      $display("FAIL reset_idle: got wg=%b st=%h expected 0/000",
               bus.wgrant, bus.stall_num);
    end
    bus.wen = 4'b0100;
    #1;
    checks++;
    if (bus.wgrant !== 4'b0100) begin
      errors++;
      $display("FAIL reset_single: got %b expected 0100", bus.wgrant);
    end
    tick();
  endtask

  task automatic test_write_rr();
    logic [3:0] g;
    do_reset();
    bus.wen = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      g = 4'b0001 << k;
      #1;
      checks++;
      if (bus.wgrant !== g) begin
        errors++;
        $display("FAIL wr_rr_grant%0d: got %b expected %b", k, bus.wgrant, g);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (bus.stall_num[i*3 +: 3] !== ((i == k) ? 3'd0 : 3'd6)) begin
          errors++;
          $display("FAIL wr_rr_stall c%0d cyc%0d: got %0d expected %0d", i, k,
                   bus.stall_num[i*3 +: 3], (i == k) ? 0 : 6);
        end
      end
      tick();
    end
  endtask

  task automatic test_read();
    logic [3:0] exp_g[3];
    int loser[3];
    exp_g = '{4'b0001, 4'b0100, 4'b0001};
    loser = '{2, 0, 2};
    do_reset();
    bus.rreq = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.rgrant !== exp_g[k] || bus.wgrant !== 4'b0000) begin
        errors++;
        $display("FAIL rd_rr%0d: got rg=%b wg=%b expected rg=%b wg=0000",
                 k, bus.rgrant, bus.wgrant, exp_g[k]);
      end
      checks++;
      if (bus.stall_num[loser[k]*3 +: 3] !== 3'd3) begin
        errors++;
        $display("FAIL rd_stall%0d: got %0d expected 3", k,
                 bus.stall_num[loser[k]*3 +: 3]);
      end
      tick();
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    set_cmd(1, 3, 1'b0);
    #1;
    checks++;
    if (bus.stall_num[9 +: 3] !== 3'd6) begin
      errors++;
      $display("FAIL pause_stall: got %0d expected 6", bus.stall_num[9 +: 3]);
    end
    tick();
    clear_in();
    bus.wen = 4'b1000;
    #1;
    checks++;
    if (bus.running !== 4'b0111 || bus.wgrant !== 4'b0000) begin
      errors++;
      $display("FAIL paused_state: got run=%b wg=%b expected 0111/0000",
               bus.running, bus.wgrant);
    end
    tick();
    set_cmd(0, 3, 1'b1);
    #1;
    checks++;
    if (bus.stall_num[9 +: 3] !== 3'd0 || bus.wgrant !== 4'b1000) begin
      errors++;
      $display("FAIL resume_same_cycle: got st=%0d wg=%b expected 0/1000",
               bus.stall_num[9 +: 3], bus.wgrant);
    end
    tick();
    clear_in();
    #1;
    checks++;
    if (bus.running !== 4'b1111) begin
      errors++;
      $display("FAIL resume_running: got %b expected 1111", bus.running);
    end
  endtask

  task automatic test_priority();
    do_reset();
    set_cmd(1, 1, 1'b0);
    tick();
    clear_in();
    set_cmd(0, 1, 1'b1);
    set_cmd(2, 1, 1'b0);
    #1;
    checks++;
    if (bus.running !== 4'b1101 || bus.stall_num[3 +: 3] !== 3'd0) begin
      errors++;
      $display("FAIL prio_resume: got run=%b st=%0d expected 1101/0",
               bus.running, bus.stall_num[3 +: 3]);
    end
    tick();
    clear_in();
    set_cmd(0, 1, 1'b0);
    set_cmd(2, 1, 1'b1);
    #1;
    checks++;
    if (bus.running !== 4'b1111) begin
      errors++;
      $display("FAIL prio_running: got %b expected 1111", bus.running);
    end
    tick();
    clear_in();
    #1;
    checks++;
    if (bus.running !== 4'b1101) begin
      errors++;
      $display("FAIL prio_pause: got %b expected 1101", bus.running);
    end
  endtask

  task automatic test_halt();
    logic [3:0] hin[4];
    logic exp_h[4];
    hin   = '{4'b1110, 4'b1111, 4'b0000, 4'b0000};
    exp_h = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.halt_in = hin[k];
      reset = (k == 3);
      tick();
      #1;
      checks++;
      if (bus.halt !== exp_h[k]) begin
        errors++;
        $display("FAIL halt%0d: got %b expected %b", k, bus.halt, exp_h[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      clear_in();
      reset       = ($urandom_range(0, 59) == 0);
      bus.wen     = 4'($urandom);
      bus.rreq    = 4'($urandom);
      bus.halt_in = 4'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0)
          set_cmd(i, $urandom_range(0, 3), 1'($urandom));
      model_eval();
      #1;
      checks++;
      if (bus.wgrant !== e_wg || bus.rgrant !== e_rg) begin
        errors++;
        $display("FAIL rnd_grant n=%0d: got wg=%b rg=%b expected wg=%b rg=%b",
                 n, bus.wgrant, bus.rgrant, e_wg, e_rg);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (bus.stall_num[i*3 +: 3] !== 3'(e_st[i])) begin
          errors++;
          $display("FAIL rnd_stall n=%0d c%0d: got %0d expected %0d",
                   n, i, bus.stall_num[i*3 +: 3], e_st[i]);
        end
      end
      checks++;
      if (bus.running !== run_vec() || bus.halt !== m_halt ||
          bus.conflicts !== 16'(m_conf)) begin
        errors++;
        $display("FAIL rnd_state n=%0d: got run=%b h=%b c=%0d expected run=%b h=%b c=%0d",
                 n, bus.running, bus.halt, bus.conflicts,
                 run_vec(), m_halt, m_conf);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_conflicts();
    int ncyc;
    logic [15:0] exp_c;
`ifdef MULTICORE_CTRL_CONFLICT_CNT_EN
    ncyc  = 70000;
    exp_c = 16'hFFFF;
`else
    ncyc  = 50;
    exp_c = 16'h0000;
`endif
    do_reset();
    bus.wen = 4'b0011;
    for (int k = 0; k < ncyc; k++) tick();
    #1;
    checks++;
    if (bus.conflicts !== exp_c) begin
      errors++;
      $display("FAIL conflicts: got %h expected %h", bus.conflicts, exp_c);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    for (int i = 0; i < N; i++) m_run[i] = 1;
    m_wptr = 0;
    m_rptr = 0;
    m_halt = 0;
    m_conf = 0;
    @(negedge clk);
    test_reset();
    test_write_rr();
    test_read();
    test_pause_resume();
    test_priority();
    test_halt();
    test_random();
    test_conflicts();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicore_ctrl.md
MULTICORE_CTRL -- requirements
Module: multicore_ctrl

Interface
REQ-001 Parameter NCORES, default 4, number of cores sharing memory; legal range 2..8.
REQ-002 Parameter IDW, default 2, core-id width; SHALL equal ceil(log2(NCORES)).
REQ-003 Parameter STALL_PR, default 6, stall count applied to a paused core.
REQ-004 Parameter STALL_WR, default 6, stall count for a lost write arbitration.
REQ-005 Parameter STALL_RD, default 3, stall count for a lost data-read arbitration.
REQ-006 Parameter RUN_INIT, default all ones (NCORES bits), per-core run state after reset.
REQ-007 Port clk  in  1  sole clock; all state changes on posedge clk.
REQ-008 Port reset  in  1  synchronous, active-high reset.
REQ-009 Port halt_in  in  NCORES  per-core halt indication.
REQ-010 Port wen  in  NCORES  per-core write request to the shared write port.
REQ-011 Port rreq  in  NCORES  per-core request for the shared data-read port (raddr bit 16).
REQ-012 Port pr_valid  in  NCORES  per-core pause/resume command valid.
REQ-013 Port pr_run  in  NCORES  command value per issuer: 1 resume, 0 pause.
REQ-014 Port pr_target  in  NCORES*IDW  target core id per issuer; slice i belongs to core i.
REQ-015 Port stall_num  out  3*NCORES  stall count per core; slice i belongs to core i.
REQ-016 Port wgrant, rgrant  out  NCORES each  one-hot (or zero) grant of the write and read ports.
REQ-017 Port running  out  NCORES  registered run state per core.
REQ-018 Port halt  out  1  registered, sticky system halt.
REQ-019 Port conflicts  out  16  arbitration conflict counter (see Configuration).

Function
REQ-020 Command resolution: per target, the lowest-index issuer with pr_valid=1 wins; commands with pr_target >= NCORES are ignored.
REQ-021 running[t] SHALL load the winning pr_run for target t on the next posedge; otherwise it holds.
REQ-022 Core i is pause-blocked this cycle if a winning pause targets i, or running[i]=0 and no winning resume targets i.
REQ-023 A pause-blocked core SHALL receive stall_num=STALL_PR and SHALL not be eligible for any grant.
REQ-024 Write arbitration: among eligible cores with wen=1, grant one by round-robin starting at wptr; wptr SHALL advance to (granted+1) mod NCORES on the next posedge; no request leaves wptr unchanged.
REQ-025 Read arbitration: identical scheme using rreq and an independent rptr.
REQ-026 Non-blocked losers: stall_num=STALL_WR if the write was lost, else STALL_RD if the read was lost, else 0; write loss takes priority.
REQ-027 A core granted both ports SHALL receive stall_num=0; grants and stall_num are combinational from current inputs and state, latency zero.
REQ-028 halt SHALL rise on the posedge after halt_in is all ones and remain 1 until reset.
REQ-029 A single requester is always granted regardless of pointer position; pointer wrap from NCORES-1 to 0.

Reset
REQ-030 On reset=1 at posedge: running<=RUN_INIT, wptr<=0, rptr<=0, halt<=0, conflicts<=0; commands in that cycle are discarded.
REQ-031 Reset asserted mid-operation SHALL override all pending commands and halt; combinational outputs reflect reset-state values from the following cycle.

Configuration
REQ-032 Macro MULTICORE_CTRL_CONFLICT_CNT_EN defined: conflicts increments by one each cycle in which at least one core loses a write or read arbitration (not pause blocks), saturating at 16'hFFFF.
REQ-033 Macro undefined: conflicts SHALL be constant 0 and no counter register is synthesised.

Verification
REQ-034 Reset, then wen=4'b1111 four consecutive cycles -> wgrant 0001,0010,0100,1000; losers stall_num=6 each cycle.
REQ-035 rreq=4'b0101 only -> rgrant 0001 then 0100; core losing gets stall_num=3; wgrant=0.
REQ-036 Core 1 issues pause target 3 -> core 3 stall_num=6 same cycle, running[3]=0 next cycle; core 0 resume target 3 later -> core 3 stall_num=0 that cycle, running[3]=1 next.
REQ-037 Cores 0 and 2 issue resume and pause to target 1 same cycle -> core 0 wins, running[1]=1.
REQ-038 halt_in=4'b1111 -> halt=1 next cycle, stays 1 after halt_in=0; reset -> halt=0.
REQ-039 With CONFLICT_CNT_EN, 70000 cycles wen=4'b0011 -> conflicts=16'hFFFF; without macro conflicts=0.
